// File: rtl/sample_frame_fifo.sv
// sample_frame_fifo
// Collects serial per-channel samples into CHANNELS-wide frames and queues
// complete frames in a DEPTH-entry first-word-fall-through FIFO. Sticky
// Overflow/Misalign flags report dropped frames and out-of-place start-of-frame.
module sample_frame_fifo #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [WIDTH-1:0]             Data_In,
  input  logic                         Valid_In,
  input  logic                         Sof_In,
  output logic [CHANNELS*WIDTH-1:0]    Frame_Out,
  output logic                         Valid_Out,
  input  logic                         Ready_Out,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         Full,
  output logic                         Overflow,
  output logic                         Misalign,
  input  logic                         Clear_Flags
);

  localparam int FW    = CHANNELS * WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNTW  = AW + 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Shadow slots hold channels 0..CHANNELS-2; keep at least one slot so the
  // array is legal when CHANNELS=1 (it is then never written or read).
  localparam int SLOTS = (CHANNELS > 1) ? CHANNELS - 1 : 1;

  localparam logic [CW-1:0]   LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Assembly stage
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    chan;
  logic [CW-1:0]    eff_chan;
  logic [WIDTH-1:0] shadow [SLOTS];
  logic             frame_done;
  logic             misalign_set;
  logic [FW-1:0]    frame_in;

  // A Sof sample always lands in channel 0, whatever the current index is.
  assign eff_chan     = Sof_In ? '0 : chan;
  assign frame_done   = Valid_In && (eff_chan == LAST_CHAN);
  assign misalign_set = Valid_In && Sof_In && (chan != '0);

  // Channel index: advance on each valid sample, wrap after the last channel.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      chan <= '0;
    end else if (Valid_In) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (frame_done) chan <= '0;
      else            chan <= eff_chan + CW'(1);
    end
  end

  // Shadow register: capture every sample except the frame-completing one.
  always_ff @(posedge Clk) begin
    if (Valid_In && !frame_done) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (eff_chan == CW'(i)) shadow[i] <= Data_In;
      end
    end
  end

  // Completed frame: earlier channels from the shadow, last channel live.
  always_comb begin
    // NOTE: a default before any conditional/loop assignment keeps this purely
    // combinational; a missed path would otherwise infer a latch.
    frame_in = '0;
    for (int i = 0; i < CHANNELS - 1; i++) begin
      frame_in[i*WIDTH +: WIDTH] = shadow[i];
    end
    frame_in[(CHANNELS-1)*WIDTH +: WIDTH] = Data_In;
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [FW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count_r;
  logic [CNTW-1:0] count_next;
  logic            valid_r;
  logic            full_r;
  logic            pop;
  logic            push_ok;
  logic            overflow_set;

  assign pop          = valid_r && Ready_Out;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok      = frame_done && ((count_r < DEPTH_CNT) || pop);
  assign overflow_set = frame_done && !push_ok;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next = count_r;
    case ({push_ok, pop})
      2'b10:   count_next = count_r + CNTW'(1);
      2'b01:   count_next = count_r - CNTW'(1);
      default: count_next = count_r;
    endcase
  end

  // Frame storage: written only on an accepted push.
  always_ff @(posedge Clk) begin
    // NOTE: the array carries no reset; valid_r gates every read, so stale
    // contents are never observable and the array can map to plain storage.
    if (push_ok) mem[wr_ptr] <= frame_in;
  end

  // Pointers, occupancy and the registered status derived from it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count_r <= count_next;
      valid_r <= (count_next != '0);
      full_r  <= (count_next == DEPTH_CNT);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set event outranks a coincident clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Overflow <= 1'b0;
      Misalign <= 1'b0;
    end else begin
      if (overflow_set)     Overflow <= 1'b1;
      else if (Clear_Flags) Overflow <= 1'b0;
      if (misalign_set)     Misalign <= 1'b1;
      else if (Clear_Flags) Misalign <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Frame_Out = valid_r ? mem[rd_ptr] : '0;
  assign Valid_Out = valid_r;
  assign Count     = count_r;
  assign Full      = full_r;

endmodule

// File: tb/tb_sample_frame_fifo.sv
// Directed self-checking bench for sample_frame_fifo (WIDTH=16, CHANNELS=2,
// DEPTH=8). Inputs change on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
module tb_sample_frame_fifo;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Data_In;
  logic        Valid_In;
  logic        Sof_In;
  logic [31:0] Frame_Out;
  logic        Valid_Out;
  logic        Ready_Out;
  logic [3:0]  Count;
  logic        Full;
  logic        Overflow;
  logic        Misalign;
  logic        Clear_Flags;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic        ovf_model;

  always #5 Clk = ~Clk;

  sample_frame_fifo #(.WIDTH(16), .CHANNELS(2), .DEPTH(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Data_In     (Data_In),
    .Valid_In    (Valid_In),
    .Sof_In      (Sof_In),
    .Frame_Out   (Frame_Out),
    .Valid_Out   (Valid_Out),
    .Ready_Out   (Ready_Out),
    .Count       (Count),
    .Full        (Full),
    .Overflow    (Overflow),
    .Misalign    (Misalign),
    .Clear_Flags (Clear_Flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic cycle(input logic v, input logic s, input logic [15:0] d,
                       input logic rdy, input logic clr, input logic rst);
    @(negedge Clk);
    Valid_In    = v;
    Sof_In      = s;
    Data_In     = d;
    Ready_Out   = rdy;
    Clear_Flags = clr;
    Rst         = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] lo, input logic [15:0] hi, input logic rdy);
    cycle(1'b1, 1'b1, lo, rdy, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, hi, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 16'h0, rdy, 1'b0, 1'b0);
  endtask

  // Random-stall step against a queue scoreboard.
  task automatic wrap_step(input logic v, input logic s, input logic [15:0] d,
                           input logic rdy, input logic completes, input logic [31:0] frame);
    logic popped;
    int   size_before;
    @(negedge Clk);
    Valid_In    = v;
    Sof_In      = s;
    Data_In     = d;
    Ready_Out   = rdy;
    Clear_Flags = 1'b0;
    Rst         = 1'b0;
    popped      = Valid_Out && rdy;
    if (popped && q.size() != 0) check("wrap_data", Frame_Out, q[0]);
    @(posedge Clk);
    size_before = q.size();
    if (popped && q.size() != 0) void'(q.pop_front());
    if (completes) begin
      if (size_before < 8 || popped) q.push_back(frame);
      else                           ovf_model = 1'b1;
    end
    #1;
    check("wrap_count", {28'h0, Count}, q.size());
  endtask

  initial begin
    Rst = 1'b1; Valid_In = 1'b0; Sof_In = 1'b0; Data_In = '0;
    Ready_Out = 1'b0; Clear_Flags = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("rst_count",    {28'h0, Count}, 32'd0);
    check("rst_valid",    {31'h0, Valid_Out}, 32'd0);
    check("rst_frame",    Frame_Out, 32'h0);
    check("rst_full",     {31'h0, Full}, 32'd0);
    check("rst_overflow", {31'h0, Overflow}, 32'd0);
    check("rst_misalign", {31'h0, Misalign}, 32'd0);

    // First frame: latency of one cycle after the last sample
    cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    check("first_half_valid", {31'h0, Valid_Out}, 32'd0);
    cycle(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0);
    check("first_valid", {31'h0, Valid_Out}, 32'd1);
    check("first_frame", Frame_Out, 32'h2222_1111);
    check("first_count", {28'h0, Count}, 32'd1);
    idle(1'b1);
    check("first_pop_valid", {31'h0, Valid_Out}, 32'd0);
    check("first_pop_frame", Frame_Out, 32'h0);

    // Fill to full, then overflow
    for (int k = 1; k <= 8; k++) send_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
    check("fill_full",  {31'h0, Full}, 32'd1);
    check("fill_count", {28'h0, Count}, 32'd8);
    check("fill_no_ovf", {31'h0, Overflow}, 32'd0);
    send_frame(16'h1009, 16'h2009, 1'b0);
    check("ovf_flag",  {31'h0, Overflow}, 32'd1);
    check("ovf_count", {28'h0, Count}, 32'd8);
    idle(1'b0);
    check("ovf_sticky", {31'h0, Overflow}, 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ovf_cleared", {31'h0, Overflow}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      check("drain_frame", Frame_Out, {16'h2000 + 16'(k), 16'h1000 + 16'(k)});
      idle(1'b1);
    end
    check("drain_valid", {31'h0, Valid_Out}, 32'd0);
    check("drain_frame_zero", Frame_Out, 32'h0);
    check("drain_count", {28'h0, Count}, 32'd0);
    check("drain_full", {31'h0, Full}, 32'd0);

    // Full with simultaneous pop and push
    for (int k = 1; k <= 8; k++) send_frame(16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
    cycle(1'b1, 1'b1, 16'h3009, 1'b0, 1'b0, 1'b0);
    check("pp_head", Frame_Out, 32'h4001_3001);
    cycle(1'b1, 1'b0, 16'h4009, 1'b1, 1'b0, 1'b0);
    check("pp_count", {28'h0, Count}, 32'd8);
    check("pp_no_ovf", {31'h0, Overflow}, 32'd0);
    check("pp_full", {31'h0, Full}, 32'd1);
    for (int k = 2; k <= 9; k++) begin
      check("pp_drain", Frame_Out, {16'h4000 + 16'(k), 16'h3000 + 16'(k)});
      idle(1'b1);
    end
    check("pp_empty", {31'h0, Valid_Out}, 32'd0);

    // Misalign: partial frame discarded
    cycle(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    check("mis_before", {31'h0, Misalign}, 32'd0);
    cycle(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    check("mis_flag", {31'h0, Misalign}, 32'd1);
    check("mis_count0", {28'h0, Count}, 32'd0);
    cycle(1'b1, 1'b0, 16'hCCCC, 1'b0, 1'b0, 1'b0);
    check("mis_count", {28'h0, Count}, 32'd1);
    check("mis_frame", Frame_Out, 32'hCCCC_BBBB);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("mis_cleared", {31'h0, Misalign}, 32'd0);
    check("mis_popped", {28'h0, Count}, 32'd0);

    // Set beats a coincident clear
    cycle(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
    check("set_wins", {31'h0, Misalign}, 32'd1);
    cycle(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    check("set_wins_frame", Frame_Out, 32'h0003_0002);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

    // Wrap-around with random stalls
    ovf_model = 1'b0;
    q.delete();
    for (int k = 0; k < 20; k++) begin
      wrap_step(1'b1, 1'b1, 16'h5000 + 16'(k), ($urandom_range(0, 3) != 0), 1'b0, 32'h0);
      wrap_step(1'b1, 1'b0, 16'h6000 + 16'(k), ($urandom_range(0, 3) != 0), 1'b1,
                {16'h6000 + 16'(k), 16'h5000 + 16'(k)});
    end
    for (int i = 0; i < 12; i++) wrap_step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
    check("wrap_empty", {31'h0, Valid_Out}, 32'd0);
    check("wrap_ovf", {31'h0, Overflow}, {31'h0, ovf_model});

    // Reset mid-frame with frames stored and a flag set
    for (int k = 1; k <= 3; k++) send_frame(16'h7000 + 16'(k), 16'h7100 + 16'(k), 1'b0);
    cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", {28'h0, Count}, 32'd3);
    check("pre_rst_mis", {31'h0, Misalign}, 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_count", {28'h0, Count}, 32'd0);
    check("mid_rst_valid", {31'h0, Valid_Out}, 32'd0);
    check("mid_rst_mis", {31'h0, Misalign}, 32'd0);
    check("mid_rst_ovf", {31'h0, Overflow}, 32'd0);
    cycle(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0, 1'b0);
    check("post_rst_half", {31'h0, Valid_Out}, 32'd0);
    cycle(1'b1, 1'b0, 16'h8888, 1'b0, 1'b0, 1'b0);
    check("post_rst_frame", Frame_Out, 32'h8888_7777);
    check("post_rst_count", {28'h0, Count}, 32'd1);
    check("post_rst_mis", {31'h0, Misalign}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_frame_fifo.md
# sample_frame_fifo

Single-clock, parametrised multi-channel sample buffer in the DSP domain. Collects serial per-channel samples from the DSP core into frames of CHANNELS samples and queues complete frames in a DEPTH-entry FIFO. The buffered frames feed the fast-to-slow crossing toward the I2S output path. Detects overflow and channel misalignment with sticky flags.

## Interface
- WIDTH, 16: bits per sample.
- CHANNELS, 2: samples per frame (≥1); channel 0 occupies Frame_Out[WIDTH-1:0].
- DEPTH, 8: FIFO capacity in frames; power of two, ≥2.
- Clk  in  1  DSP clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Data_In  in  WIDTH  sample from the DSP core.
- Valid_In  in  1  Data_In is valid this cycle (one sample per cycle max).
- Sof_In  in  1  qualified by Valid_In: this sample is channel 0 of a new frame.
- Frame_Out  out  CHANNELS*WIDTH  head-of-FIFO frame (first-word fall-through).
- Valid_Out  out  1  FIFO non-empty.
- Ready_Out  in  1  consumer accepts the head frame when Valid_Out is high.
- Count  out  $clog2(DEPTH)+1  frames stored (0..DEPTH).
- Full  out  1  Count == DEPTH.
- Overflow  out  1  sticky: a completed frame was dropped.
- Misalign  out  1  sticky: Sof_In arrived mid-frame.
- Clear_Flags  in  1  clears Overflow and Misalign.

## Operation
- Assembly stage: channel index Chan (0..CHANNELS-1) and a (CHANNELS-1)*WIDTH shadow register.
  - Valid_In && !Sof_In: Data_In stored at slot Chan; Chan increments.
  - Valid_In && Sof_In: Data_In stored as channel 0; Chan := 1. If Chan was ≠0, the partial frame is discarded and Misalign is set.
  - When the accepted sample is channel CHANNELS-1, the completed frame {Data_In, shadow} is pushed, and Chan wraps to 0. With CHANNELS=1, every valid sample is a complete frame.
  - Valid_In low: no state change.
- FIFO: register array of DEPTH×(CHANNELS*WIDTH), read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Pop = Valid_Out && Ready_Out.
  - Push is accepted if Count < DEPTH, or if a pop occurs in the same cycle.
  - A push while full without a simultaneous pop drops the frame and sets Overflow; stored contents are unchanged.
  - Simultaneous accepted push and pop: Count unchanged, both pointers advance.
- Frame_Out is mem[rd_ptr] when Valid_Out is high, and all zeros when the FIFO is empty.
- Flags:
  - Overflow and Misalign hold until Clear_Flags or Rst.
  - Clear_Flags coincident with a new set event: the set wins.
- Reset values:
  - Valid_Out=0, Frame_Out=0, Count=0, Full=0, Overflow=0, Misalign=0.
  - Chan=0, both pointers=0.
  - The memory array is not reset.
- Rst mid-frame or with frames stored: everything is discarded; first post-reset sample is channel 0.

## Timing
- Latency: last-channel sample accepted at edge t → Valid_Out=1, Count incremented, and the frame on Frame_Out after edge t (1 cycle).
- Pop at edge t → the next frame (or zeros if the FIFO empties) appears after edge t.
- Full, Count, and Valid_Out are registered and update on the same edge as the push/pop.
- Overflow and Misalign assert the cycle after the offending edge.
- Sustained throughput: one frame per CHANNELS cycles in, one frame per cycle out.

## Test plan
- Reset, CHANNELS=2, WIDTH=16: push samples 0x1111, 0x2222 (Sof on first) → Valid_Out=1 one cycle after the second sample; Frame_Out=0x2222_1111; Count=1.
- Fill: 8 frames with Ready_Out=0 → Full=1, Count=8. Push a 9th → Overflow=1, Count=8. Then drain with Ready_Out=1 → frames 1..8 emerge in order, then Valid_Out=0 and Frame_Out=0.
- Full plus simultaneous pop and 9th-frame push → push accepted, no Overflow, Count stays 8; the 9th frame emerges last.
- Misalign: sample 0xAAAA (Sof), then 0xBBBB with Sof, then 0xCCCC → Misalign=1, and the only frame stored is 0xCCCC_BBBB.
- Wrap-around: 20 frames streamed with random Ready_Out stalls → output matches the scoreboard exactly; Count never exceeds 8.
- Rst asserted mid-frame with 3 frames stored → next cycle Count=0, Valid_Out=0, flags 0. A new 2-sample frame then emerges intact.
